// File: rtl/mem_responder.sv
// Wait-state memory responder: one request at a time, single-cycle response strobe.
// Optional MEM_PARITY_EN stores an even-parity bit per word and flags mismatches.
module mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [15:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [15:0]       read_count,
  output logic [15:0]       write_count
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t            state_q;
  logic [3:0]        wcnt_q;
  logic              we_q;
  logic [15:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              valid_q;
  logic              err_q;
  logic [15:0]       rd_cnt_q;
  logic [15:0]       wr_cnt_q;
  logic [15:0]       rd_cnt_d;
  logic [15:0]       wr_cnt_d;
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic              in_range;
  logic              err_d;

  assign idx      = addr_q[ADDR_W-1:0];
  assign in_range = (addr_q >> ADDR_W) == 16'd0;
  assign rd_cnt_d = (rd_cnt_q == 16'hFFFF) ? rd_cnt_q : rd_cnt_q + 16'd1;
  assign wr_cnt_d = (wr_cnt_q == 16'hFFFF) ? wr_cnt_q : wr_cnt_q + 16'd1;

`ifdef MEM_PARITY_EN
  logic par_q [2**ADDR_W];

  // only reads check parity; the stored bit makes the word even
  assign err_d = !in_range ||
                 (!we_q && ((^mem_q[idx]) != par_q[idx]));
`else
  assign err_d = !in_range;
`endif

  always_ff @(posedge CLK) begin
    if (!reset && state_q == ACCESS && we_q && in_range) begin
      mem_q[idx] <= wdata_q;
`ifdef MEM_PARITY_EN
      par_q[idx] <= ^wdata_q;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wcnt_q  <= WAIT_INIT;
            state_q <= (WAIT_CYCLES > 0) ? WAIT : ACCESS;
          end
        end
        WAIT: begin
          wcnt_q <= wcnt_q - 4'd1;
          if (wcnt_q == 4'd1) state_q <= ACCESS;
        end
        ACCESS: begin
          if (!we_q) rdata_q <= in_range ? mem_q[idx] : '0;
          valid_q <= 1'b1;
          err_q   <= err_d;
          state_q <= RESP;
        end
        RESP: begin
          valid_q <= 1'b0;
          err_q   <= 1'b0;
          if (we_q) wr_cnt_q <= wr_cnt_d;
          else      rd_cnt_q <= rd_cnt_d;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign rsp_valid   = valid_q;
  assign rsp_err     = err_q;
  assign rsp_rdata   = rdata_q;
  assign read_count  = rd_cnt_q;
  assign write_count = wr_cnt_q;

endmodule
